// File: rtl/fetch_if.sv
// Fetch-side bundle: decode/execute redirect inputs, instruction memory port and IF/ID outputs.
// Signal prefixes are as seen from the fetch unit; fetch uses "slave" and decode/memory use "master".
interface fetch_if;
    logic        i_con_stall;
    logic [1:0]  i_con_jump;
    logic [31:0] i_addr_jump;
    logic [31:0] i_data_jr;
    logic        i_con_branch;
    logic [31:0] i_addr_branch;
    logic        o_con_imemreq;
    logic [31:0] o_addr_imem;
    logic        i_con_imemready;
    logic [31:0] i_data_imem;
    logic [31:0] o_addr_pc4;
    logic [31:0] o_data_instr;
    logic        o_con_valid;

    modport slave (
        input  i_con_stall, i_con_jump, i_addr_jump, i_data_jr,
        input  i_con_branch, i_addr_branch, i_con_imemready, i_data_imem,
        output o_con_imemreq, o_addr_imem, o_addr_pc4, o_data_instr, o_con_valid
    );

    modport master (
        output i_con_stall, i_con_jump, i_addr_jump, i_data_jr,
        output i_con_branch, i_addr_branch, i_con_imemready, i_data_imem,
        input  o_con_imemreq, o_addr_imem, o_addr_pc4, o_data_instr, o_con_valid
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch with IF/ID register; a memory completion reaches IF/ID on the same clock edge.
// Decode stall parks a completed word in a hold buffer and stops requests until the stall drops.
module fetch #(
    parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
    input  logic   i_clk,
    input  logic   i_rst,
    fetch_if.slave io_bus
);
    typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_drop_addr;
    logic [31:0] r_hold_pc4;
    logic [31:0] r_hold_instr;
    logic [31:0] r_pc4;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_drop;
    logic        r_jpend;

    logic        w_jump_vld;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;

    assign w_jump_vld = ((io_bus.i_con_jump == 2'b01) || (io_bus.i_con_jump == 2'b10))
                        && !io_bus.i_con_stall;
    assign w_jump_tgt = (io_bus.i_con_jump == 2'b01) ? io_bus.i_addr_jump : io_bus.i_data_jr;
    assign w_pc4      = r_pc + 32'd4;
    assign w_next_pc  = w_jump_vld ? w_jump_tgt : (r_jpend ? r_target : w_pc4);

    // A flushed-but-open request keeps its original address until it completes.
    assign io_bus.o_con_imemreq = (r_state == S_RUN) && !i_rst;
    assign io_bus.o_addr_imem   = r_drop ? r_drop_addr : r_pc;
    assign io_bus.o_addr_pc4    = r_pc4;
    assign io_bus.o_data_instr  = r_instr;
    assign io_bus.o_con_valid   = r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_RUN;
            r_pc         <= P_RESET_PC;
            r_target     <= '0;
            r_drop_addr  <= '0;
            r_hold_pc4   <= '0;
            r_hold_instr <= '0;
            r_pc4        <= '0;
            r_instr      <= '0;
            r_valid      <= 1'b0;
            r_drop       <= 1'b0;
            r_jpend      <= 1'b0;
        end else if (io_bus.i_con_branch) begin
            r_pc4        <= '0;
            r_instr      <= '0;
            r_valid      <= 1'b0;
            r_pc         <= io_bus.i_addr_branch;
            r_jpend      <= 1'b0;
            r_state      <= S_RUN;
            r_hold_pc4   <= '0;
            r_hold_instr <= '0;
            if ((r_state == S_RUN) && !io_bus.i_con_imemready) begin
                r_drop <= 1'b1;
                if (!r_drop) begin
                    r_drop_addr <= r_pc;
                end
            end else begin
                r_drop <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            if (io_bus.i_con_imemready) begin
                if (r_drop) begin
                    // Wrong-path word: discard without touching IF/ID or the PC.
                    r_drop <= 1'b0;
                    if (w_jump_vld) begin
                        r_target <= w_jump_tgt;
                        r_jpend  <= 1'b1;
                    end
                end else begin
                    r_pc    <= w_next_pc;
                    r_jpend <= 1'b0;
                    if (io_bus.i_con_stall) begin
                        r_hold_pc4   <= w_pc4;
                        r_hold_instr <= io_bus.i_data_imem;
                        r_state      <= S_HOLD;
                    end else begin
                        r_pc4   <= w_pc4;
                        r_instr <= io_bus.i_data_imem;
                        r_valid <= 1'b1;
                    end
                end
            end else begin
                if (!io_bus.i_con_stall) begin
                    r_pc4   <= '0;
                    r_instr <= '0;
                    r_valid <= 1'b0;
                end
                if (w_jump_vld) begin
                    r_target <= w_jump_tgt;
                    r_jpend  <= 1'b1;
                end
            end
        end else begin
            if (!io_bus.i_con_stall) begin
                r_pc4   <= r_hold_pc4;
                r_instr <= r_hold_instr;
                r_valid <= 1'b1;
                r_state <= S_RUN;
            end
            // The held word is the delay slot; the PC already points past it.
            if (w_jump_vld) begin
                r_target <= w_jump_tgt;
                r_jpend  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed per-cycle vector table, reset sequences, then random traffic vs a model.
module tb_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int NV = 37;
    localparam int NRND = 3000;

    logic clk;
    logic rst;
    logic mem_scr;
    int   n_tests;
    int   n_fail;

    fetch_if bus ();

    fetch #(.P_RESET_PC(RST_PC)) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_data_imem = mem_scr ? ((bus.o_addr_imem ^ 32'hC0DE_0000) + 32'd7) : bus.o_addr_imem;

    function automatic logic [31:0] scr(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + 32'd7;
    endfunction

    typedef struct {
        logic        stall;
        logic [1:0]  jump;
        logic [31:0] aj;
        logic [31:0] jr;
        logic        br;
        logic [31:0] ab;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] epc4;
        logic [31:0] eins;
        logic        evld;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(input logic st, input logic [1:0] j, input logic [31:0] aj,
                                input logic [31:0] jr, input logic br, input logic [31:0] ab,
                                input logic rdy, input logic ereq, input logic [31:0] eaddr,
                                input logic [31:0] epc4, input logic [31:0] eins, input logic evld);
        vec_t v;
        v.stall = st; v.jump = j; v.aj = aj; v.jr = jr; v.br = br; v.ab = ab; v.rdy = rdy;
        v.ereq = ereq; v.eaddr = eaddr; v.epc4 = epc4; v.eins = eins; v.evld = evld;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] j, input logic [31:0] aj,
                         input logic [31:0] jr, input logic br, input logic [31:0] ab, input logic rdy);
        bus.i_con_stall     = st;
        bus.i_con_jump      = j;
        bus.i_addr_jump     = aj;
        bus.i_data_jr       = jr;
        bus.i_con_branch    = br;
        bus.i_addr_branch   = ab;
        bus.i_con_imemready = rdy;
    endtask

    // Reference model: what fetch has promised so far, in plain state variables.
    logic [31:0] m_pc, m_tgt, m_drop_addr, m_hpc4, m_hins, m_pc4, m_ins;
    logic        m_vld, m_drop, m_pend, m_held;

    task automatic model_reset();
        m_pc = RST_PC; m_tgt = '0; m_drop_addr = '0; m_hpc4 = '0; m_hins = '0;
        m_pc4 = '0; m_ins = '0; m_vld = 1'b0; m_drop = 1'b0; m_pend = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic [1:0] j, input logic [31:0] aj,
                              input logic [31:0] jr, input logic br, input logic [31:0] ab,
                              input logic rdy);
        logic        jv;
        logic [31:0] jt;
        logic [31:0] nxt;
        jv = ((j == 2'b01) || (j == 2'b10)) && !st;
        jt = (j == 2'b01) ? aj : jr;
        if (br) begin
            if (!m_held && !rdy) begin
                if (!m_drop) m_drop_addr = m_pc;
                m_drop = 1'b1;
            end else begin
                m_drop = 1'b0;
            end
            m_pc = ab; m_pend = 1'b0; m_held = 1'b0;
            m_pc4 = '0; m_ins = '0; m_vld = 1'b0;
            return;
        end
        if (m_held) begin
            if (!st) begin
                m_pc4 = m_hpc4; m_ins = m_hins; m_vld = 1'b1; m_held = 1'b0;
            end
        end else if (rdy && m_drop) begin
            m_drop = 1'b0;
        end else if (rdy) begin
            nxt = jv ? jt : (m_pend ? m_tgt : m_pc + 32'd4);
            if (st) begin
                m_hpc4 = m_pc + 32'd4; m_hins = scr(m_pc); m_held = 1'b1;
            end else begin
                m_pc4 = m_pc + 32'd4; m_ins = scr(m_pc); m_vld = 1'b1;
            end
            m_pc = nxt; m_pend = 1'b0;
            return;
        end else if (!st) begin
            m_pc4 = '0; m_ins = '0; m_vld = 1'b0;
        end
        if (jv) begin
            m_tgt = jt; m_pend = 1'b1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem_scr = 1'b0;
        rst     = 1'b1;
        drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);

        //           st  jmp    aj        jr        br  ab            rdy  req  addr          pc4           instr         vld
        tv[0]  = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h0,         32'h4,        32'h0,        1);
        tv[1]  = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h4,         32'h8,        32'h4,        1);
        tv[2]  = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h8,         32'hC,        32'h8,        1);
        tv[3]  = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'hC,         32'h10,       32'hC,        1);
        tv[4]  = mk(1, 2'd0, 0,        0,        0, 0,            1,   1, 32'h10,        32'h10,       32'hC,        1);
        tv[5]  = mk(1, 2'd0, 0,        0,        0, 0,            0,   0, 32'h0,         32'h10,       32'hC,        1);
        tv[6]  = mk(1, 2'd0, 0,        0,        0, 0,            0,   0, 32'h0,         32'h10,       32'hC,        1);
        tv[7]  = mk(0, 2'd0, 0,        0,        0, 0,            0,   0, 32'h0,         32'h14,       32'h10,       1);
        tv[8]  = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h14,        32'h18,       32'h14,       1);
        tv[9]  = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h18,        32'h1C,       32'h18,       1);
        tv[10] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h1C,        32'h20,       32'h1C,       1);
        tv[11] = mk(0, 2'd0, 0,        0,        1, 32'h100,      0,   1, 32'h20,        32'h0,        32'h0,        0);
        tv[12] = mk(0, 2'd0, 0,        0,        0, 0,            0,   1, 32'h20,        32'h0,        32'h0,        0);
        tv[13] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h20,        32'h0,        32'h0,        0);
        tv[14] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h100,       32'h104,      32'h100,      1);
        tv[15] = mk(0, 2'd0, 0,        0,        1, 32'h30,       1,   1, 32'h104,       32'h0,        32'h0,        0);
        tv[16] = mk(0, 2'd1, 32'h400,  0,        0, 0,            0,   1, 32'h30,        32'h0,        32'h0,        0);
        tv[17] = mk(0, 2'd0, 0,        0,        0, 0,            0,   1, 32'h30,        32'h0,        32'h0,        0);
        tv[18] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h30,        32'h34,       32'h30,       1);
        tv[19] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h400,       32'h404,      32'h400,      1);
        tv[20] = mk(0, 2'd2, 0,        32'h500,  0, 0,            1,   1, 32'h404,       32'h408,      32'h404,      1);
        tv[21] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h500,       32'h504,      32'h500,      1);
        tv[22] = mk(1, 2'd2, 0,        32'h600,  1, 32'h80,       1,   1, 32'h504,       32'h0,        32'h0,        0);
        tv[23] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h80,        32'h84,       32'h80,       1);
        tv[24] = mk(0, 2'd3, 32'h700,  32'h704,  0, 0,            1,   1, 32'h84,        32'h88,       32'h84,       1);
        tv[25] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h88,        32'h8C,       32'h88,       1);
        tv[26] = mk(1, 2'd1, 32'h900,  0,        0, 0,            0,   1, 32'h8C,        32'h8C,       32'h88,       1);
        tv[27] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h8C,        32'h90,       32'h8C,       1);
        tv[28] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h90,        32'h94,       32'h90,       1);
        tv[29] = mk(0, 2'd0, 0,        0,        1, 32'hFFFF_FFFC,1,   1, 32'h94,        32'h0,        32'h0,        0);
        tv[30] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFC,1);
        tv[31] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h0,         32'h4,        32'h0,        1);
        tv[32] = mk(0, 2'd0, 0,        0,        1, 32'h203,      1,   1, 32'h4,         32'h0,        32'h0,        0);
        tv[33] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h203,       32'h207,      32'h203,      1);
        tv[34] = mk(1, 2'd0, 0,        0,        0, 0,            1,   1, 32'h207,       32'h207,      32'h203,      1);
        tv[35] = mk(1, 2'd0, 0,        0,        1, 32'h40,       0,   0, 32'h0,         32'h0,        32'h0,        0);
        tv[36] = mk(0, 2'd0, 0,        0,        0, 0,            1,   1, 32'h40,        32'h44,       32'h40,       1);

        repeat (2) @(negedge clk);
        chk("rst_req",   0, {31'd0, bus.o_con_imemreq}, 32'd0);
        chk("rst_valid", 0, {31'd0, bus.o_con_valid},   32'd0);
        chk("rst_pc4",   0, bus.o_addr_pc4,             32'd0);
        chk("rst_instr", 0, bus.o_data_instr,           32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].stall, tv[i].jump, tv[i].aj, tv[i].jr, tv[i].br, tv[i].ab, tv[i].rdy);
            #1;
            chk("vec_req", i, {31'd0, bus.o_con_imemreq}, {31'd0, tv[i].ereq});
            if (tv[i].ereq) chk("vec_addr", i, bus.o_addr_imem, tv[i].eaddr);
            @(negedge clk);
            chk("vec_pc4",   i, bus.o_addr_pc4,           tv[i].epc4);
            chk("vec_instr", i, bus.o_data_instr,         tv[i].eins);
            chk("vec_valid", i, {31'd0, bus.o_con_valid}, {31'd0, tv[i].evld});
        end

        // Reset asserted between edges must clear outputs without waiting for a clock.
        drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_req",   0, {31'd0, bus.o_con_imemreq}, 32'd0);
        chk("arst_valid", 0, {31'd0, bus.o_con_valid},   32'd0);
        chk("arst_pc4",   0, bus.o_addr_pc4,             32'd0);
        chk("arst_instr", 0, bus.o_data_instr,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_scr = 1'b1;
        #1;
        chk("arst_rel_req",  0, {31'd0, bus.o_con_imemreq}, 32'd1);
        chk("arst_rel_addr", 0, bus.o_addr_imem,            RST_PC);
        model_reset();

        for (int c = 0; c < NRND; c++) begin
            logic        st, br, rdy;
            logic [1:0]  j;
            logic [31:0] aj, jr, ab;
            if (c == NRND / 2) begin
                drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
                #2 rst = 1'b1;
                #1 chk("rnd_arst_valid", c, {31'd0, bus.o_con_valid}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            #1;
            chk("rnd_req",   c, {31'd0, bus.o_con_imemreq}, {31'd0, !m_held});
            if (!m_held) chk("rnd_addr", c, bus.o_addr_imem, m_drop ? m_drop_addr : m_pc);
            chk("rnd_pc4",   c, bus.o_addr_pc4,           m_pc4);
            chk("rnd_instr", c, bus.o_data_instr,         m_ins);
            chk("rnd_valid", c, {31'd0, bus.o_con_valid}, {31'd0, m_vld});
            st  = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            aj  = $urandom;
            jr  = $urandom;
            br  = ($urandom_range(0, 9) == 0);
            ab  = $urandom;
            rdy = ($urandom_range(0, 2) != 0);
            drive(st, j, aj, jr, br, ab, rdy);
            model_step(st, j, aj, jr, br, ab, rdy);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter P_RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_con_stall  in  1  decode stall: hold the IF/ID register and suppress new fetches.
- i_con_jump  in  2  decode jump type: 00 none, 01 j/jal, 10 jr, 11 reserved (treated as 00).
- i_addr_jump  in  32  j/jal target.
- i_data_jr  in  32  jr target.
- i_con_branch  in  1  execute branch taken.
- i_addr_branch  in  32  branch target.
- o_con_imemreq  out  1  instruction memory request.
- o_addr_imem  out  32  request address.
- i_con_imemready  in  1  request completes this cycle.
- i_data_imem  in  32  instruction word, valid when ready is high.
- o_addr_pc4  out  32  IF/ID: fetched PC+4.
- o_data_instr  out  32  IF/ID: instruction, 0 (NOP) when invalid.
- o_con_valid  out  1  IF/ID holds a real instruction.

Function
REQ-003 Memory protocol: a request completes on a cycle with o_con_imemreq=1 and i_con_imemready=1. While a request is open, o_addr_imem is stable and o_con_imemreq stays high until that request completes.
REQ-004 FSM states: RUN, HOLD.
- RUN: o_con_imemreq=1, o_addr_imem=r_pc.
- HOLD: o_con_imemreq=0.
REQ-005 Branch flush (i_con_branch=1) has top priority, regardless of stall or state. It writes a bubble into IF/ID (valid=0, instr=0, pc4=0), sets r_pc to i_addr_branch, and clears the pending-jump flag.
- If a request completes that same cycle, its data is discarded.
- If a request is open and not ready, set the drop flag. The next completion is discarded and does not advance r_pc.
- In HOLD, the hold buffer is discarded and the FSM goes to RUN.
REQ-006 Jump (i_con_jump=01/10 with i_con_stall=0) uses delay-slot semantics.
- The instruction completing this cycle, or the open request's completion, is delivered normally.
- The following fetch uses the target (01: i_addr_jump, 10: i_data_jr).
- If nothing completes this cycle, the target is latched in r_target and the pending-jump flag is set.
REQ-007 Jump is ignored while i_con_stall=1; decode presents it again after the stall.
REQ-008 In RUN, on a completion with no branch, no drop and i_con_stall=0:
- IF/ID gets {r_pc+4, i_data_imem, valid=1}.
- r_pc gets the jump target if a jump is present this cycle or pending (the pending flag then clears); otherwise r_pc+4.
REQ-009 In RUN, on a completion with i_con_stall=1: i_data_imem and r_pc+4 are captured in the hold buffer, r_pc advances per REQ-008, IF/ID holds, and the FSM goes to HOLD.
REQ-010 In RUN with no completion: if i_con_stall=1, IF/ID holds; otherwise IF/ID gets a bubble.
REQ-011 In HOLD with i_con_stall=0: IF/ID gets {hold pc4, hold instr, valid=1} and the FSM goes to RUN. With i_con_stall=1, everything holds.
REQ-012 A dropped completion clears the drop flag and writes nothing to IF/ID.
REQ-013 PC arithmetic is 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 = 0. Bits [1:0] of targets are passed through unchanged.
REQ-014 The reset vector is the instruction after a bubble; there is no fetch latency beyond the memory's own.

Reset
REQ-015 While i_rst=1, asynchronously:
- r_pc=P_RESET_PC, state=RUN.
- Drop flag, pending-jump flag, r_target and hold buffer are cleared.
- o_addr_pc4=0, o_data_instr=0, o_con_valid=0.
REQ-016 o_con_imemreq=0 while i_rst=1. On the first clock edge after release, a request for P_RESET_PC is issued.
REQ-017 Reset in the middle of an open request abandons it. Any later ready pulse for that request is undefined to the bench and is not driven.

Verification
REQ-018 Zero-wait stream:
- Stimulus: ready tied high, memory returns word = address.
- Response: IF/ID shows pc4 = 4, 8, 12, ... with instr = 0, 4, 8 in consecutive cycles, valid=1.
REQ-019 Stall during completion:
- Stimulus: stall=1 for 3 cycles while the word for 0x10 completes.
- Response: FSM goes to HOLD, req=0, IF/ID unchanged. One cycle after stall drops, IF/ID = {0x14, mem[0x10]}, and the next request address is 0x14.
REQ-020 Branch with an open request:
- Stimulus: ready low with request at 0x20 open, branch=1 to 0x100. Ready arrives 2 cycles later.
- Response: a bubble is written, the 0x20 data is discarded, and the next request is 0x100.
REQ-021 Jump delay slot:
- Stimulus: jump=01 to 0x400 while the request at 0x30 waits 2 cycles.
- Response: the 0x30 instruction is delivered with valid=1, and the next request is 0x400.
REQ-022 Simultaneous events:
- Stimulus: branch=1 to 0x80 together with stall=1 and jump=10 in the same cycle.
- Response: branch wins, IF/ID gets a bubble, the next request is 0x80, and the jump is ignored.
REQ-023 Asynchronous reset:
- Stimulus: i_rst pulsed between clock edges.
- Response: outputs are 0 immediately. After release, the first request is at P_RESET_PC.
